apb3_iaddr_width_bridge: RTL and testbench

Downstream consumer of the APB3 indirect address register. It accepts 32-bit APB3 transfers on a slave port and forms a full 32-bit target address by combining the indirect address register value (IADDR) with the low PADDR bits. It then replays each transfer on a narrower APB3 master port as 1, 2 or 4 sequential beats. It sits between the APB3 interconnect slot and narrow peripherals that need a wide address space.

---
 rtl/apb3_iaddr_width_bridge_if.sv | 24 ++
 rtl/apb3_iaddr_width_bridge.sv | 143 ++++++++++++++
 tb/tb_apb3_iaddr_width_bridge.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb3_iaddr_width_bridge_if.sv
// APB3 bus bundle shared by the wide upstream port and the narrow downstream port.
// DWIDTH sets the data width; the address is always 32 bits.
interface apb3_iaddr_width_bridge_if #(
    parameter int DWIDTH = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb3_iaddr_width_bridge.sv
// Splits each 32-bit APB3 transfer into 32/SLV_DWIDTH narrow beats whose
// address is formed from the indirect address register and the low PADDR bits.
module apb3_iaddr_width_bridge #(
    parameter int SLV_DWIDTH = 8,
    parameter int OFF_BITS   = 12
) (
    input  logic                      PCLK,
    input  logic                      PRESETN,
    input  logic [31:0]               IADDR,
    apb3_iaddr_width_bridge_if.slave  up,
    apb3_iaddr_width_bridge_if.master dn
);
    localparam int NB = 32 / SLV_DWIDTH;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [31:0] LO_MASK = (32'h1 << OFF_BITS) - 32'h1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                  state, next_state;
    logic [KW-1:0]           k, k_d;
    logic [31:0]             wdata, wdata_d;
    logic [31:0]             rbuf, rbuf_d;
    logic                    err, err_d;
    logic [31:0]             base;
    logic                    capture, beat_done, last_beat;

    logic                    m_psel_q, m_penable_q, m_pwrite_q;
    logic [31:0]             m_paddr_q;
    logic [SLV_DWIDTH-1:0]   m_pwdata_q;
    logic [31:0]             prdata_q;
    logic                    pready_q, pslverr_q;

    logic                    m_psel_d, m_penable_d, m_pwrite_d;
    logic [31:0]             m_paddr_d;
    logic [SLV_DWIDTH-1:0]   m_pwdata_d;
    logic [31:0]             prdata_d;
    logic                    pready_d, pslverr_d;

    // Masking whole words keeps every IADDR/PADDR bit in the expression; beats are word aligned.
    assign base      = ((IADDR & ~LO_MASK) | (up.paddr & LO_MASK)) & ~32'h3;
    assign capture   = (state == IDLE) && up.psel && !up.penable;
    assign beat_done = (state == ACCESS) && dn.pready;
    assign last_beat = dn.pslverr || (k == KW'(NB - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        // NOTE: a default for every always_comb output comes first so no path infers a latch.
        next_state = state;
        case (state)
            IDLE:    if (capture) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (dn.pready) next_state = last_beat ? DONE : SETUP;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture, read-data collection and per-beat address/data advance.
    always_comb begin
        k_d        = k;
        wdata_d    = wdata;
        rbuf_d     = rbuf;
        err_d      = err;
        m_pwrite_d = m_pwrite_q;
        m_paddr_d  = m_paddr_q;
        m_pwdata_d = m_pwdata_q;
        if (capture) begin
            k_d        = '0;
            wdata_d    = up.pwdata;
            rbuf_d     = '0;
            err_d      = 1'b0;
            m_pwrite_d = up.pwrite;
            m_paddr_d  = base;
            m_pwdata_d = up.pwdata[SLV_DWIDTH-1:0];
        end else if (beat_done) begin
            err_d = err | dn.pslverr;
            if (!m_pwrite_q) begin
                for (int b = 0; b < NB; b++)
                    if (k == KW'(b)) rbuf_d[b*SLV_DWIDTH +: SLV_DWIDTH] = dn.prdata;
            end
            if (!last_beat) begin
                k_d       = k + 1'b1;
                m_paddr_d = m_paddr_q + 32'd4;
                for (int b = 0; b < NB; b++)
                    if (k_d == KW'(b)) m_pwdata_d = wdata[b*SLV_DWIDTH +: SLV_DWIDTH];
            end
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        m_psel_d    = (next_state == SETUP) || (next_state == ACCESS);
        m_penable_d = (next_state == ACCESS);
        pready_d    = (next_state == DONE);
        pslverr_d   = (next_state == DONE) && err_d;
        prdata_d    = ((next_state == DONE) && !m_pwrite_q) ? rbuf_d : 32'h0;
    end

    // NOTE: the read buffer is a handful of flops, not a RAM, so it is reset like any other register.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            k           <= '0;
            wdata       <= '0;
            rbuf        <= '0;
            err         <= 1'b0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
        end else begin
            k           <= k_d;
            wdata       <= wdata_d;
            rbuf        <= rbuf_d;
            err         <= err_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwrite_q  <= m_pwrite_d;
            m_paddr_q   <= m_paddr_d;
            m_pwdata_q  <= m_pwdata_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
        end
    end

    assign dn.psel    = m_psel_q;
    assign dn.penable = m_penable_q;
    assign dn.pwrite  = m_pwrite_q;
    assign dn.paddr   = m_paddr_q;
    assign dn.pwdata  = m_pwdata_q;
    assign up.prdata  = prdata_q;
    assign up.pready  = pready_q;
    assign up.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb3_iaddr_width_bridge.sv
// Directed bench for the IADDR width bridge: 8-, 16- and 32-bit downstream
// instances share clock and reset; narrow slaves are modelled with per-beat tables.
module tb_apb3_iaddr_width_bridge;
    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] iaddr8, iaddr16, iaddr32;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 pclk = ~pclk;

    apb3_iaddr_width_bridge_if #(.DWIDTH(32)) up8  ();
    apb3_iaddr_width_bridge_if #(.DWIDTH(8))  dn8  ();
    apb3_iaddr_width_bridge_if #(.DWIDTH(32)) up16 ();
    apb3_iaddr_width_bridge_if #(.DWIDTH(16)) dn16 ();
    apb3_iaddr_width_bridge_if #(.DWIDTH(32)) up32 ();
    apb3_iaddr_width_bridge_if #(.DWIDTH(32)) dn32 ();

    apb3_iaddr_width_bridge #(.SLV_DWIDTH(8),  .OFF_BITS(12)) u_dut8 (
        .PCLK(pclk), .PRESETN(presetn), .IADDR(iaddr8),  .up(up8),  .dn(dn8));
    apb3_iaddr_width_bridge #(.SLV_DWIDTH(16), .OFF_BITS(12)) u_dut16 (
        .PCLK(pclk), .PRESETN(presetn), .IADDR(iaddr16), .up(up16), .dn(dn16));
    apb3_iaddr_width_bridge #(.SLV_DWIDTH(32), .OFF_BITS(12)) u_dut32 (
        .PCLK(pclk), .PRESETN(presetn), .IADDR(iaddr32), .up(up32), .dn(dn32));

    // Narrow slave models: per-beat wait count, error and read data; completed beats are logged.
    int          wait8[4];
    bit          err8[4];
    logic [7:0]  rdat8[4];
    int          nb8, wc8;
    logic [31:0] log_addr8[8];
    logic [7:0]  log_wd8[8];

    int          wait16[4];
    bit          err16[4];
    logic [15:0] rdat16[4];
    int          nb16, wc16;
    logic [31:0] log_addr16[8];

    bit          cyc_psel[32];
    bit          cyc_pen[32];
    logic [31:0] cyc_paddr[32];
    logic [31:0] cyc_pwdata[32];

    initial begin
        dn8.pready = 1'b0; dn8.pslverr = 1'b0; dn8.prdata = '0; nb8 = 0; wc8 = 0;
        forever begin
            @(negedge pclk);
            if (up8.psel && !up8.penable) begin
                nb8 = 0; wc8 = 0; dn8.pready = 1'b0; dn8.pslverr = 1'b0;
            end else if (dn8.psel && dn8.penable) begin
                if (wc8 < wait8[nb8 & 3]) begin
                    dn8.pready = 1'b0; wc8++;
                end else begin
                    dn8.pready = 1'b1; dn8.pslverr = err8[nb8 & 3]; dn8.prdata = rdat8[nb8 & 3];
                    if (nb8 < 8) begin log_addr8[nb8] = dn8.paddr; log_wd8[nb8] = dn8.pwdata; end
                    nb8++; wc8 = 0;
                end
            end else begin
                dn8.pready = 1'b0; dn8.pslverr = 1'b0; wc8 = 0;
            end
        end
    end

    initial begin
        dn16.pready = 1'b0; dn16.pslverr = 1'b0; dn16.prdata = '0; nb16 = 0; wc16 = 0;
        forever begin
            @(negedge pclk);
            if (up16.psel && !up16.penable) begin
                nb16 = 0; wc16 = 0; dn16.pready = 1'b0; dn16.pslverr = 1'b0;
            end else if (dn16.psel && dn16.penable) begin
                if (wc16 < wait16[nb16 & 3]) begin
                    dn16.pready = 1'b0; wc16++;
                end else begin
                    dn16.pready = 1'b1; dn16.pslverr = err16[nb16 & 3]; dn16.prdata = rdat16[nb16 & 3];
                    if (nb16 < 8) log_addr16[nb16] = dn16.paddr;
                    nb16++; wc16 = 0;
                end
            end else begin
                dn16.pready = 1'b0; dn16.pslverr = 1'b0; wc16 = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents an upstream setup phase; the next edge is the capture edge E0.
    task automatic start_xfer(input int sel, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, output logic rdy_setup);
        @(posedge pclk); #1;
        case (sel)
            8:  begin up8.psel = 1'b1;  up8.penable = 1'b0;  up8.pwrite = wr;  up8.paddr = addr;  up8.pwdata = wd;  end
            16: begin up16.psel = 1'b1; up16.penable = 1'b0; up16.pwrite = wr; up16.paddr = addr; up16.pwdata = wd; end
            default: begin up32.psel = 1'b1; up32.penable = 1'b0; up32.pwrite = wr; up32.paddr = addr; up32.pwdata = wd; end
        endcase
        @(negedge pclk);
        rdy_setup = (sel == 8) ? up8.pready : (sel == 16) ? up16.pready : up32.pready;
        @(posedge pclk); #1;
        case (sel)
            8:       up8.penable = 1'b1;
            16:      up16.penable = 1'b1;
            default: up32.penable = 1'b1;
        endcase
    endtask

    // Samples cycles E0+1.. at the falling edge until PREADY; n stays 0 if the budget expires.
    task automatic wait_ready(input int sel, output int n, output logic [31:0] rd, output logic er);
        logic rdy;
        n = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge pclk);
            case (sel)
                8: begin
                    cyc_psel[c] = dn8.psel; cyc_pen[c] = dn8.penable;
                    cyc_paddr[c] = dn8.paddr; cyc_pwdata[c] = 32'(dn8.pwdata);
                    rdy = up8.pready; rd = up8.prdata; er = up8.pslverr;
                end
                16: begin
                    cyc_psel[c] = dn16.psel; cyc_pen[c] = dn16.penable;
                    cyc_paddr[c] = dn16.paddr; cyc_pwdata[c] = 32'(dn16.pwdata);
                    rdy = up16.pready; rd = up16.prdata; er = up16.pslverr;
                end
                default: begin
                    cyc_psel[c] = dn32.psel; cyc_pen[c] = dn32.penable;
                    cyc_paddr[c] = dn32.paddr; cyc_pwdata[c] = dn32.pwdata;
                    rdy = up32.pready; rd = up32.prdata; er = up32.pslverr;
                end
            endcase
            if (rdy) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int          n;
        logic [31:0] rd;
        logic        er, rs;

        presetn = 1'b1;
        iaddr8 = '0; iaddr16 = '0; iaddr32 = '0;
        up8.psel = 0;  up8.penable = 0;  up8.pwrite = 0;  up8.paddr = '0;  up8.pwdata = '0;
        up16.psel = 0; up16.penable = 0; up16.pwrite = 0; up16.paddr = '0; up16.pwdata = '0;
        up32.psel = 0; up32.penable = 0; up32.pwrite = 0; up32.paddr = '0; up32.pwdata = '0;
        dn32.pready = 1'b1; dn32.pslverr = 1'b0; dn32.prdata = '0;
        wait8 = '{0, 0, 0, 0};  err8 = '{0, 0, 0, 0};  rdat8 = '{8'h0, 8'h0, 8'h0, 8'h0};
        wait16 = '{0, 0, 0, 0}; err16 = '{0, 0, 0, 0}; rdat16 = '{16'h0, 16'h0, 16'h0, 16'h0};

        // Reset values
        #3 presetn = 1'b0;
        #1;
        check("rst_pready8",   32'(up8.pready),   32'h0);
        check("rst_prdata8",   up8.prdata,        32'h0);
        check("rst_pslverr8",  32'(up8.pslverr),  32'h0);
        check("rst_m_psel8",   32'(dn8.psel),     32'h0);
        check("rst_m_pen8",    32'(dn8.penable),  32'h0);
        check("rst_m_pwrite8", 32'(dn8.pwrite),   32'h0);
        check("rst_m_paddr8",  dn8.paddr,         32'h0);
        check("rst_m_pwdata8", 32'(dn8.pwdata),   32'h0);
        check("rst_m_paddr16", dn16.paddr,        32'h0);
        check("rst_pready32",  32'(up32.pready),  32'h0);
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        check("idle_m_psel8",  32'(dn8.psel),     32'h0);

        // 8-bit write, zero wait: four beats, PREADY at E0+9
        iaddr8 = 32'hABCD_E000;
        start_xfer(8, 1'b1, 32'h0000_0124, 32'h1122_3344, rs);
        wait_ready(8, n, rd, er);
        check("w8_ready_cycle", 32'(n), 32'd9);
        check("w8_prdata",      rd, 32'h0);
        check("w8_pslverr",     32'(er), 32'h0);
        check("w8_setup_addr",  cyc_paddr[1], 32'hABCD_E124);
        check("w8_acc_pen",     32'(cyc_pen[2]), 32'h1);
        check("w8_gap_psel",    32'(cyc_psel[3]), 32'h1);
        check("w8_gap_pen",     32'(cyc_pen[3]), 32'h0);
        check("w8_beats",       32'(nb8), 32'd4);
        check("w8_addr0", log_addr8[0], 32'hABCD_E124);
        check("w8_addr1", log_addr8[1], 32'hABCD_E128);
        check("w8_addr2", log_addr8[2], 32'hABCD_E12C);
        check("w8_addr3", log_addr8[3], 32'hABCD_E130);
        check("w8_data0", 32'(log_wd8[0]), 32'h44);
        check("w8_data1", 32'(log_wd8[1]), 32'h33);
        check("w8_data2", 32'(log_wd8[2]), 32'h22);
        check("w8_data3", 32'(log_wd8[3]), 32'h11);

        // Back-to-back wrap write; IADDR/PADDR/PWDATA scrambled after capture
        iaddr8 = 32'hFFFF_F000;
        start_xfer(8, 1'b1, 32'h0000_0FF8, 32'hA1B2_C3D4, rs);
        check("b2b_ready_one_cycle", 32'(rs), 32'h0);
        iaddr8 = 32'h0; up8.paddr = 32'h0; up8.pwdata = 32'h0;
        wait_ready(8, n, rd, er);
        check("wrap_ready_cycle", 32'(n), 32'd9);
        check("wrap_addr0", log_addr8[0], 32'hFFFF_FFF8);
        check("wrap_addr1", log_addr8[1], 32'hFFFF_FFFC);
        check("wrap_addr2", log_addr8[2], 32'h0000_0000);
        check("wrap_addr3", log_addr8[3], 32'h0000_0004);
        check("wrap_data0", 32'(log_wd8[0]), 32'hD4);
        check("wrap_data3", 32'(log_wd8[3]), 32'hA1);
        @(posedge pclk); #1;
        up8.psel = 1'b0; up8.penable = 1'b0;

        // 8-bit read, error on beat 1 aborts the rest
        iaddr8 = 32'h0001_0000;
        rdat8 = '{8'h5A, 8'h00, 8'h77, 8'h88};
        err8 = '{0, 1, 0, 0};
        start_xfer(8, 1'b0, 32'h0000_0040, 32'h0, rs);
        wait_ready(8, n, rd, er);
        check("err_ready_cycle", 32'(n), 32'd5);
        check("err_prdata",      rd, 32'h0000_005A);
        check("err_pslverr",     32'(er), 32'h1);
        check("err_beats",       32'(nb8), 32'd2);
        @(posedge pclk); #1;
        up8.psel = 1'b0; up8.penable = 1'b0;
        @(negedge pclk);
        check("err_pslverr_drop", 32'(up8.pslverr), 32'h0);
        check("err_pready_drop",  32'(up8.pready),  32'h0);
        repeat (4) @(negedge pclk);
        check("err_no_more_beats", 32'(nb8), 32'd2);
        check("err_m_psel_idle",   32'(dn8.psel), 32'h0);
        err8 = '{0, 0, 0, 0};

        // 16-bit read with 3 waits on beat 0; PSEL dropped after capture
        iaddr16 = 32'h4000_0000;
        wait16 = '{3, 0, 0, 0};
        rdat16 = '{16'hBEEF, 16'hDEAD, 16'h0, 16'h0};
        start_xfer(16, 1'b0, 32'h0000_0010, 32'h0, rs);
        up16.psel = 1'b0; up16.penable = 1'b0;
        wait_ready(16, n, rd, er);
        check("r16_ready_cycle", 32'(n), 32'd8);
        check("r16_prdata",      rd, 32'hDEAD_BEEF);
        check("r16_pslverr",     32'(er), 32'h0);
        check("r16_wait_pen",    32'(cyc_pen[5]), 32'h1);
        check("r16_gap_psel",    32'(cyc_psel[6]), 32'h1);
        check("r16_gap_pen",     32'(cyc_pen[6]), 32'h0);
        check("r16_addr0",       log_addr16[0], 32'h4000_0010);
        check("r16_addr1",       log_addr16[1], 32'h4000_0014);
        @(negedge pclk);
        check("r16_back_idle",   32'(up16.pready), 32'h0);

        // Reset asserted during ACCESS of beat 2
        iaddr8 = 32'h0000_2000;
        wait8 = '{0, 0, 5, 0};
        start_xfer(8, 1'b1, 32'h0000_0000, 32'h0102_0304, rs);
        repeat (6) @(negedge pclk);
        check("rst_mid_in_access", 32'(dn8.penable), 32'h1);
        check("rst_mid_beats",     32'(nb8), 32'd2);
        presetn = 1'b0;
        #1;
        check("rst_mid_m_psel",   32'(dn8.psel),    32'h0);
        check("rst_mid_m_pen",    32'(dn8.penable), 32'h0);
        check("rst_mid_pready",   32'(up8.pready),  32'h0);
        check("rst_mid_m_paddr",  dn8.paddr,        32'h0);
        up8.psel = 1'b0; up8.penable = 1'b0;
        wait8 = '{0, 0, 0, 0};
        @(posedge pclk); #1;
        presetn = 1'b1;
        repeat (2) @(negedge pclk);
        check("rst_mid_no_beat",  32'(nb8), 32'd2);
        check("rst_mid_idle",     32'(dn8.psel), 32'h0);

        // 32-bit write: single beat, PREADY at E0+3
        iaddr32 = 32'h1234_5000;
        start_xfer(32, 1'b1, 32'h0000_00AC, 32'hCAFE_F00D, rs);
        wait_ready(32, n, rd, er);
        check("w32_ready_cycle", 32'(n), 32'd3);
        check("w32_setup_psel",  32'(cyc_psel[1]), 32'h1);
        check("w32_setup_pen",   32'(cyc_pen[1]), 32'h0);
        check("w32_acc_pen",     32'(cyc_pen[2]), 32'h1);
        check("w32_addr",        cyc_paddr[1], 32'h1234_50AC);
        check("w32_wdata",       cyc_pwdata[1], 32'hCAFE_F00D);
        check("w32_pwrite",      32'(dn32.pwrite), 32'h1);
        check("w32_pslverr",     32'(er), 32'h0);
        @(posedge pclk); #1;
        up32.psel = 1'b0; up32.penable = 1'b0;
        @(negedge pclk);
        check("w32_pready_drop", 32'(up32.pready), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
